// File: rtl/cheri_dv_pkg.sv
// Shared CHERI DV types: error types, trap codes and the
// expected-trap lookup used by the capability-error checker.
package cheri_dv_pkg;

    typedef enum logic [2:0] {
        ERR_TAG   = 3'd0,
        ERR_SEAL  = 3'd1,
        ERR_PERM  = 3'd2,
        ERR_BOUND = 3'd3,
        ERR_ALIGN = 3'd4
    } err_type_e;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } chk_state_e;

    localparam logic [5:0] MCAUSE_CHERI = 6'd28;
    localparam logic [5:0] MCAUSE_LMIS  = 6'd4;
    localparam logic [5:0] MCAUSE_SMIS  = 6'd6;

    localparam logic [4:0] CAUSE_BOUND = 5'h01;
    localparam logic [4:0] CAUSE_TAG   = 5'h02;
    localparam logic [4:0] CAUSE_SEAL  = 5'h03;
    localparam logic [4:0] CAUSE_PEX   = 5'h11;
    localparam logic [4:0] CAUSE_PLD   = 5'h12;
    localparam logic [4:0] CAUSE_PST   = 5'h13;
    localparam logic [4:0] CAUSE_PSC   = 5'h15;

    localparam int CNT_INJ  = 0;
    localparam int CNT_PASS = 1;
    localparam int CNT_MISM = 2;
    localparam int CNT_MISS = 3;
    localparam int CNT_TMO  = 4;
    localparam int CNT_OVL  = 5;
    localparam int N_CNT    = 6;

    typedef struct packed {
        logic [5:0]  mcause;
        logic [31:0] cause_mask;
    } chk_exp_t;

    typedef struct packed {
        logic [2:0] typ;
        logic       is_cap;
        logic       is_cjalr;
        logic       we;
    } inj_cap_t;

    function automatic logic [31:0] cbit(input logic [4:0] c);
        return 32'd1 << c;
    endfunction

    // An all-zero mask means no trap can ever match (unknown type).
    function automatic chk_exp_t exp_lookup(
        input logic [2:0] typ,
        input logic       is_cap,
        input logic       is_cjalr,
        input logic       we
    );
        chk_exp_t e;
        e.mcause     = MCAUSE_CHERI;
        e.cause_mask = '0;
        if (is_cjalr) begin
            e.cause_mask = cbit(CAUSE_TAG) | cbit(CAUSE_SEAL) | cbit(CAUSE_PEX);
        end else begin
            case (err_type_e'(typ))
                ERR_TAG:   e.cause_mask = cbit(CAUSE_TAG);
                ERR_SEAL:  e.cause_mask = cbit(CAUSE_SEAL);
                ERR_PERM: begin
                    if (!we)
                        e.cause_mask = cbit(CAUSE_PLD);
                    else if (is_cap)
                        e.cause_mask = cbit(CAUSE_PST) | cbit(CAUSE_PSC);
                    else
                        e.cause_mask = cbit(CAUSE_PST);
                end
                ERR_BOUND: e.cause_mask = cbit(CAUSE_BOUND);
                ERR_ALIGN: begin
                    e.mcause     = we ? MCAUSE_SMIS : MCAUSE_LMIS;
                    e.cause_mask = '1;
                end
                default:   e.cause_mask = '0;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/cap_err_chk_if.sv
// Injector-side and trap-side inputs observed by cap_err_chk.
// master drives them (injector/core/bench), slave observes.
interface cap_err_chk_if;
    logic       err_active_i;
    logic       err_failed_i;
    logic [7:0] err_flag_i;
    logic       is_cap_i;
    logic       is_cjalr_i;
    logic       we_i;
    logic       exc_valid_i;
    logic [5:0] exc_mcause_i;
    logic [4:0] exc_cheri_cause_i;

    modport master (
        output err_active_i, err_failed_i, err_flag_i,
        output is_cap_i, is_cjalr_i, we_i,
        output exc_valid_i, exc_mcause_i, exc_cheri_cause_i
    );

    modport slave (
        input err_active_i, err_failed_i, err_flag_i,
        input is_cap_i, is_cjalr_i, we_i,
        input exc_valid_i, exc_mcause_i, exc_cheri_cause_i
    );
endinterface

// File: rtl/cap_err_chk_cnt.sv
// Saturating statistics counter with synchronous clear;
// clear takes priority over a same-cycle increment.
module cap_err_chk_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/cap_err_chk.sv
// Checks each injected CHERI error against the trap the core takes.
// Define CAP_ERR_CHK_FATAL_EN to stop simulation on any failure.
module cap_err_chk
    import cheri_dv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    cap_err_chk_if.slave     bus,
    output logic             busy_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] inj_cnt_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] mism_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] tmo_cnt_o,
    output logic [CNT_W-1:0] ovl_cnt_o
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    chk_state_e       state_q, state_d;
    logic             act_q, act_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    inj_cap_t         cap_q, cap_d;

    inj_cap_t         live, cur;
    chk_exp_t         ex;
    logic             rise, hit, eval;
    logic [N_CNT-1:0] inc;
    logic [CNT_W-1:0] cnt [N_CNT];
    logic             unused_flag;

    assign unused_flag = ^bus.err_flag_i[6:3];

    assign live = '{typ:      bus.err_flag_i[2:0],
                    is_cap:   bus.is_cap_i,
                    is_cjalr: bus.is_cjalr_i,
                    we:       bus.we_i};

    // A start evaluates against the live inputs in its own cycle.
    assign cur  = (state_q == ST_IDLE) ? live : cap_q;
    assign ex   = exp_lookup(cur.typ, cur.is_cap, cur.is_cjalr, cur.we);
    assign hit  = (bus.exc_mcause_i == ex.mcause) &&
                  ex.cause_mask[bus.exc_cheri_cause_i];
    assign rise = bus.err_active_i & ~act_q;

    always_comb begin
        state_d = state_q;
        act_d   = bus.err_active_i;
        tmr_d   = tmr_q;
        cap_d   = cap_q;
        inc     = '0;
        pass_o  = 1'b0;
        fail_o  = 1'b0;
        eval    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (rise && !bus.err_flag_i[7]) begin
                cap_d         = live;
                inc[CNT_INJ]  = 1'b1;
                eval          = 1'b1;
                state_d       = ST_WAIT;
                tmr_d         = '0;
            end
        end else begin
            inc[CNT_OVL] = rise;
            eval         = 1'b1;
        end
        if (eval) begin
            if (bus.err_failed_i) begin
                inc[CNT_MISS] = 1'b1;
                fail_o        = 1'b1;
                state_d       = ST_IDLE;
            end else if (bus.exc_valid_i) begin
                inc[CNT_PASS] = hit;
                inc[CNT_MISM] = ~hit;
                pass_o        = hit;
                fail_o        = ~hit;
                state_d       = ST_IDLE;
            end else if (state_q == ST_WAIT) begin
                if (tmr_q == TMR_LAST) begin
                    inc[CNT_TMO] = 1'b1;
                    fail_o       = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            act_q   <= 1'b0;
            tmr_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            tmr_q   <= tmr_d;
            cap_q   <= cap_d;
        end
    end

    for (genvar i = 0; i < N_CNT; i++) begin : g_cnt
        cap_err_chk_cnt #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clr_i),
            .inc_i (inc[i]),
            .cnt_o (cnt[i])
        );
    end

    assign busy_o     = (state_q == ST_WAIT);
    assign inj_cnt_o  = cnt[CNT_INJ];
    assign pass_cnt_o = cnt[CNT_PASS];
    assign mism_cnt_o = cnt[CNT_MISM];
    assign miss_cnt_o = cnt[CNT_MISS];
    assign tmo_cnt_o  = cnt[CNT_TMO];
    assign ovl_cnt_o  = cnt[CNT_OVL];

`ifdef CAP_ERR_CHK_FATAL_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= '0;
        else        cyc_q <= cyc_q + 32'd1;
    end

    always @(posedge clk) begin
        if (rst_n && fail_o)
            $fatal(1, "cap_err_chk: type %0d exp mcause %0d mask %08h got mcause %0d cause %02h cycle %0d",
                   cur.typ, ex.mcause, ex.cause_mask,
                   bus.exc_mcause_i, bus.exc_cheri_cause_i, cyc_q);
    end
`endif
endmodule

// File: tb/tb_cap_err_chk.sv
// Directed bench for cap_err_chk: a rule-level model checked every
// cycle on two instances (16-bit and 4-bit counters) plus literal pins.
module tb_cap_err_chk;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    cap_err_chk_if inj ();

    logic        busy_w, pass_w, fail_w;
    logic [15:0] inj_w, pass_cw, mism_w, miss_w, tmo_w, ovl_w;
    logic        busy_s, pass_s, fail_s;
    logic [3:0]  inj_s, pass_cs, mism_s, miss_s, tmo_s, ovl_s;

    cap_err_chk #(.TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .bus(inj),
        .busy_o(busy_w), .pass_o(pass_w), .fail_o(fail_w),
        .inj_cnt_o(inj_w), .pass_cnt_o(pass_cw), .mism_cnt_o(mism_w),
        .miss_cnt_o(miss_w), .tmo_cnt_o(tmo_w), .ovl_cnt_o(ovl_w)
    );

    cap_err_chk #(.TIMEOUT_CYC(TMO), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .bus(inj),
        .busy_o(busy_s), .pass_o(pass_s), .fail_o(fail_s),
        .inj_cnt_o(inj_s), .pass_cnt_o(pass_cs), .mism_cnt_o(mism_s),
        .miss_cnt_o(miss_s), .tmo_cnt_o(tmo_s), .ovl_cnt_o(ovl_s)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts since last clear/reset; outputs saturate per width.
    int   n [6];
    bit   m_wait, m_prev, m_cap, m_cjalr, m_we;
    logic [2:0] m_typ;
    int   m_age;

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit legal(input logic [2:0] t, input bit cap, input bit cj,
                                 input bit we, input int mc, input int cc);
        if (cj) return mc == 28 && (cc == 'h02 || cc == 'h03 || cc == 'h11);
        case (t)
            3'd0: return mc == 28 && cc == 'h02;
            3'd1: return mc == 28 && cc == 'h03;
            3'd2: begin
                if (!we) return mc == 28 && cc == 'h12;
                if (cap) return mc == 28 && (cc == 'h13 || cc == 'h15);
                return mc == 28 && cc == 'h13;
            end
            3'd3: return mc == 28 && cc == 'h01;
            3'd4: return mc == (we ? 6 : 4);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk_cnts(input string tag);
        chk({tag, "inj16"},  32'(inj_w),   32'(sat(n[0], 16)));
        chk({tag, "pass16"}, 32'(pass_cw), 32'(sat(n[1], 16)));
        chk({tag, "mism16"}, 32'(mism_w),  32'(sat(n[2], 16)));
        chk({tag, "miss16"}, 32'(miss_w),  32'(sat(n[3], 16)));
        chk({tag, "tmo16"},  32'(tmo_w),   32'(sat(n[4], 16)));
        chk({tag, "ovl16"},  32'(ovl_w),   32'(sat(n[5], 16)));
        chk({tag, "inj4"},   32'(inj_s),   32'(sat(n[0], 4)));
        chk({tag, "pass4"},  32'(pass_cs), 32'(sat(n[1], 4)));
        chk({tag, "mism4"},  32'(mism_s),  32'(sat(n[2], 4)));
        chk({tag, "miss4"},  32'(miss_s),  32'(sat(n[3], 4)));
        chk({tag, "tmo4"},   32'(tmo_s),   32'(sat(n[4], 4)));
        chk({tag, "ovl4"},   32'(ovl_s),   32'(sat(n[5], 4)));
    endtask

    always @(negedge clk) begin
        bit rise, start, ep, ef, eb;
        if (!rst_n) begin
            foreach (n[i]) n[i] = 0;
            m_wait = 0; m_prev = 0; m_age = 0;
            chk_cnts("rst_");
            chk("rst_busy", {busy_w, busy_s}, 0);
            chk("rst_pulse", {pass_w, fail_w, pass_s, fail_s}, 0);
        end else begin
            chk_cnts("m_");
            rise  = inj.err_active_i && !m_prev;
            start = 0; ep = 0; ef = 0; eb = m_wait;
            if (m_wait && rise) n[5]++;
            if (!m_wait && rise && !inj.err_flag_i[7]) begin
                start = 1; n[0]++;
                m_typ = inj.err_flag_i[2:0];
                m_cap = inj.is_cap_i; m_cjalr = inj.is_cjalr_i; m_we = inj.we_i;
            end
            if (m_wait || start) begin
                if (inj.err_failed_i) begin
                    n[3]++; ef = 1; m_wait = 0;
                end else if (inj.exc_valid_i) begin
                    if (legal(m_typ, m_cap, m_cjalr, m_we,
                              int'(inj.exc_mcause_i), int'(inj.exc_cheri_cause_i))) begin
                        n[1]++; ep = 1;
                    end else begin
                        n[2]++; ef = 1;
                    end
                    m_wait = 0;
                end else if (start) begin
                    m_wait = 1; m_age = 1;
                end else if (m_age == TMO) begin
                    n[4]++; ef = 1; m_wait = 0;
                end else begin
                    m_age++;
                end
            end
            if (clr) foreach (n[i]) n[i] = 0;
            m_prev = inj.err_active_i;
            chk("busy16", busy_w, eb);
            chk("busy4",  busy_s, eb);
            chk("pass16", pass_w, ep);
            chk("pass4",  pass_s, ep);
            chk("fail16", fail_w, ef);
            chk("fail4",  fail_s, ef);
        end
    end

    task automatic setf(input logic [7:0] f, input bit cap, input bit cj, input bit we);
        inj.err_flag_i = f; inj.is_cap_i = cap; inj.is_cjalr_i = cj; inj.we_i = we;
    endtask

    task automatic put(input bit act, input bit failed, input bit exc,
                       input logic [5:0] mc, input logic [4:0] cc);
        inj.err_active_i = act; inj.err_failed_i = failed;
        inj.exc_valid_i = exc; inj.exc_mcause_i = mc; inj.exc_cheri_cause_i = cc;
    endtask

    task automatic drv(input bit act, input bit failed, input bit exc,
                       input logic [5:0] mc, input logic [4:0] cc);
        put(act, failed, exc, mc, cc);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int k);
        repeat (k) drv(0, 0, 0, 6'd0, 5'd0);
    endtask

    task automatic drv_pin(input string nm, input bit act, input bit exc,
                           input logic [5:0] mc, input logic [4:0] cc,
                           input bit xp, input bit xf);
        put(act, 0, exc, mc, cc);
        #3;
        chk({nm, "_pass_o"}, pass_w, xp);
        chk({nm, "_fail_o"}, fail_w, xf);
        @(posedge clk); #1;
    endtask

    initial begin
        setf(8'h00, 0, 0, 0);
        put(0, 0, 0, 6'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // type 0 load, trap three cycles after the injection edge
        drv(1, 0, 0, 6'd0, 5'd0);
        chk("t1_busy", busy_w, 1);
        idle(2);
        drv_pin("t1", 0, 1, 6'd28, 5'h02, 1, 0);
        chk("t1_pass_cnt", pass_cw, 1);
        chk("t1_inj_cnt", inj_w, 1);
        chk("t1_busy_after", busy_w, 0);
        idle(1);

        // type 3 store sees a tag cause
        setf(8'h03, 0, 0, 1);
        drv(1, 0, 0, 6'd0, 5'd0); idle(1);
        drv(0, 0, 1, 6'd28, 5'h02);
        chk("t2_mism_cnt", mism_w, 1);
        idle(1);

        // type 2 CSC
        setf(8'h02, 1, 0, 1);
        drv(1, 0, 0, 6'd0, 5'd0); drv(0, 0, 1, 6'd28, 5'h15);
        drv(1, 0, 0, 6'd0, 5'd0); drv(0, 0, 1, 6'd28, 5'h13);
        drv(1, 0, 0, 6'd0, 5'd0); drv(0, 0, 1, 6'd28, 5'h12);
        chk("t3_pass_cnt", pass_cw, 3);
        chk("t3_mism_cnt", mism_w, 2);
        idle(1);

        // timeout: 64 waiting cycles with no trap
        setf(8'h00, 0, 0, 0);
        drv(1, 0, 0, 6'd0, 5'd0);
        idle(TMO - 1);
        chk("t4_busy_pre", busy_w, 1);
        drv_pin("t4", 0, 0, 6'd0, 5'd0, 0, 1);
        chk("t4_tmo_cnt", tmo_w, 1);
        chk("t4_busy_post", busy_w, 0);

        // err_failed two cycles after injection
        drv(1, 0, 0, 6'd0, 5'd0); idle(1);
        drv(0, 1, 0, 6'd0, 5'd0);
        chk("t5_miss_cnt", miss_w, 1);

        // second edge while waiting
        drv(1, 0, 0, 6'd0, 5'd0); idle(1);
        drv(1, 0, 0, 6'd0, 5'd0);
        drv(0, 0, 1, 6'd28, 5'h02);
        chk("t6_ovl_cnt", ovl_w, 1);
        chk("t6_inj_cnt", inj_w, 8);

        // CJALR and alignment, start and trap in one cycle
        setf(8'h04, 0, 1, 0);
        drv_pin("t7a", 1, 1, 6'd28, 5'h11, 1, 0); idle(1);
        setf(8'h04, 1, 0, 0);
        drv_pin("t7b", 1, 1, 6'd4, 5'h1f, 1, 0); idle(1);
        setf(8'h04, 1, 0, 1);
        drv_pin("t7c", 1, 1, 6'd28, 5'h02, 0, 1); idle(1);
        chk("t7_pass_cnt", pass_cw, 6);
        chk("t7_mism_cnt", mism_w, 3);
        chk("t7_busy", busy_w, 0);

        // give-up flag is ignored
        setf(8'h80, 0, 0, 0);
        drv(1, 0, 0, 6'd0, 5'd0); idle(3);
        chk("t8_inj_cnt", inj_w, 11);
        chk("t8_busy", busy_w, 0);

        // saturation of the narrow instance
        setf(8'h00, 0, 0, 0);
        repeat (20) begin
            drv(1, 0, 1, 6'd28, 5'h02); idle(1);
        end
        chk("t9_pass_sat", pass_cs, 4'hF);
        chk("t9_inj_sat", inj_s, 4'hF);
        chk("t9_pass_wide", pass_cw, 26);

        // clear on the same cycle as a pass
        clr = 1'b1;
        drv(1, 0, 1, 6'd28, 5'h02);
        clr = 1'b0;
        chk("t10_pass_cnt", pass_cw, 0);
        chk("t10_inj_cnt", inj_w, 0);
        chk("t10_sum4", 32'(inj_s) + 32'(pass_cs) + 32'(mism_s) + 32'(ovl_s), 0);
        idle(1);

        // reset in the middle of a wait
        drv(1, 0, 0, 6'd0, 5'd0); idle(1);
        chk("t11_busy_pre", busy_w, 1);
        rst_n = 1'b0;
        #1;
        chk("t11_busy_rst", busy_w, 0);
        chk("t11_fail_rst", fail_w, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);
        chk("t11_busy_post", busy_w, 0);
        chk("t11_inj_cnt", inj_w, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
